mem_read_arbiter: RTL and testbench

- Sits directly downstream of the ray pipeline's cache miss handlers (icache, t0cache, lcache) and upstream of the SDRAM controller read port.
- Accepts per-cache burst read requests and grants one at a time, round-robin.
- Issues one burst to SDRAM, then steers the returned words back to the granted cache.
- Marks the final word with doneRead.

---
 rtl/mem_read_arbiter_pkg.sv | 37 +++
 rtl/mem_read_arbiter_rr_pick.sv | 29 ++
 rtl/mem_read_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_arbiter_pkg.sv
// Shared sizing and types for the SDRAM read arbiter that serves the icache, t0cache and lcache miss handlers.
// The client-count and burst-length defaults come from the defines below.
`ifndef numCaches
`define numCaches 3
`endif
`ifndef maxTrans
`define maxTrans 16
`endif

package mem_read_arbiter_pkg;
  localparam int NUM_CLIENTS = `numCaches;
  localparam int MAX_TRANS   = `maxTrans;
  localparam int ADDR_W      = 25;
  localparam int DATA_W      = 32;
  localparam int SZ_W        = $clog2(MAX_TRANS);
  localparam int IDX_W       = $clog2(NUM_CLIENTS);

  typedef logic [IDX_W-1:0] client_idx_t;
  typedef logic [SZ_W-1:0]  size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } mem_arb_state_t;

  function automatic client_idx_t next_client(input client_idx_t idx);
    return (int'(idx) >= NUM_CLIENTS - 1) ? '0 : client_idx_t'(int'(idx) + 1);
  endfunction

  function automatic logic [NUM_CLIENTS-1:0] client_onehot(input client_idx_t idx);
    logic [NUM_CLIENTS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/mem_read_arbiter_rr_pick.sv
// Rotate-priority picker: scans the request vector starting at ptr_i and wrapping,
// returning the first requester found.
module rr_pick
  import mem_read_arbiter_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  client_idx_t            ptr_i,
  output client_idx_t            winner_o,
  output logic                   found_o
);
  int          idx;
  client_idx_t sel;

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      sel = client_idx_t'(idx);
      if (!found_o && req_i[sel]) begin
        found_o  = 1'b1;
        winner_o = sel;
      end
    end
  end
endmodule

// File: rtl/mem_read_arbiter.sv
// Grants one cache burst read at a time to the SDRAM read port and steers the beats back.
// Define MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (client 0 highest).
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr_cache_to_sdram,
  input  logic [NUM_CLIENTS-1:0][SZ_W-1:0]   transSize,
  input  logic [NUM_CLIENTS-1:0]             readReq,
  output logic [NUM_CLIENTS-1:0]             readValid_out,
  output logic [NUM_CLIENTS-1:0][DATA_W-1:0] readData,
  output logic [NUM_CLIENTS-1:0]             doneRead,
  output logic                              sdram_req,
  output logic [ADDR_W-1:0]                 sdram_addr,
  output logic [SZ_W-1:0]                   sdram_size,
  input  logic                              sdram_ack,
  input  logic                              sdram_rvalid,
  input  logic [DATA_W-1:0]                 sdram_rdata,
  output mem_arb_state_t                    dbg_state_o
);
  // Handshake: sdram_req stays high with addr/size stable until the cycle sdram_ack is seen
  // high; beats are accepted on every sdram_rvalid while in DATA, with no backpressure.
  mem_arb_state_t         state_q, state_d;
  client_idx_t            win_q, win_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  size_t                  size_q, size_d;
  size_t                  cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [NUM_CLIENTS-1:0] valid_q, valid_d;
  logic [NUM_CLIENTS-1:0] done_q, done_d;

  client_idx_t pick_ptr;
  client_idx_t pick_win;
  logic        pick_found;
  logic        last_beat;

  rr_pick u_rr_pick (
    .req_i    (readReq),
    .ptr_i    (pick_ptr),
    .winner_o (pick_win),
    .found_o  (pick_found)
  );

  assign last_beat = (state_q == DATA) && sdram_rvalid && (cnt_q == size_q);

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  client_idx_t ptr_q;

  // The pointer only moves when a burst completes, so an aborted burst leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (last_beat) begin
      ptr_q <= next_client(win_q);
    end
  end

  assign pick_ptr = ptr_q;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    valid_d = '0;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_d   = pick_win;
          addr_d  = addr_cache_to_sdram[pick_win];
          size_d  = transSize[pick_win];
          state_d = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) state_d = DATA;
      end
      DATA: begin
        if (sdram_rvalid) begin
          rdata_d = sdram_rdata;
          valid_d = client_onehot(win_q);
          if (last_beat) begin
            cnt_d   = '0;
            done_d  = client_onehot(win_q);
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + size_t'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign readValid_out = valid_q;
  assign doneRead      = done_q;
  assign readData      = {NUM_CLIENTS{rdata_q}};
  assign sdram_req     = (state_q == REQ);
  assign sdram_addr    = addr_q;
  assign sdram_size    = size_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter: a queue-based grant-order model plus an SDRAM responder,
// with a separate monitor that scores every returned beat.
module tb_mem_read_arbiter;
  import mem_read_arbiter_pkg::*;
  localparam int N     = NUM_CLIENTS;
  localparam int EXP_W = 32 + 8 + 1 + DATA_W;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [N-1:0][ADDR_W-1:0]  addr_cache_to_sdram;
  logic [N-1:0][SZ_W-1:0]    transSize;
  logic [N-1:0]              readReq;
  logic [N-1:0]              readValid_out;
  logic [N-1:0][DATA_W-1:0]  readData;
  logic [N-1:0]              doneRead;
  logic                      sdram_req;
  logic [ADDR_W-1:0]         sdram_addr;
  logic [SZ_W-1:0]           sdram_size;
  logic                      sdram_ack;
  logic                      sdram_rvalid;
  logic [DATA_W-1:0]         sdram_rdata;
  mem_arb_state_t            dbg_state;

  mem_read_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .addr_cache_to_sdram (addr_cache_to_sdram),
    .transSize           (transSize),
    .readReq             (readReq),
    .readValid_out       (readValid_out),
    .readData            (readData),
    .doneRead            (doneRead),
    .sdram_req           (sdram_req),
    .sdram_addr          (sdram_addr),
    .sdram_size          (sdram_size),
    .sdram_ack           (sdram_ack),
    .sdram_rvalid        (sdram_rvalid),
    .sdram_rdata         (sdram_rdata),
    .dbg_state_o         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  // stimulus knobs and per-client request contents
  logic [ADDR_W-1:0] c_addr[N];
  logic [SZ_W-1:0]   c_size[N];
  int gap_mode;
  int gap_pat[$];
  int stall_fixed;
  int data_base;
  int rr_model;
  bit abort;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle; clients drop readReq as soon as their doneRead is visible.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (doneRead[i]) readReq[i] = 1'b0;
  endtask

  task automatic wait_req(output int waited);
    waited = 0;
    while (!sdram_req && waited < 20) begin
      sdram_rvalid = 1'($urandom_range(0, 1));
      sdram_rdata  = $urandom;
      step();
      waited++;
    end
    sdram_rvalid = 1'b0;
  endtask

  // ---------------- driver: one round of requests ----------------
  task automatic run_round(input logic [N-1:0] mask);
    int order[$];
    logic [N-1:0] pend;
    int waited;
    int stall;
    int gap;
    int c;
    logic [DATA_W-1:0] d;
    if (abort) return;
    // reference: serve pending clients in pointer order
    pend = mask;
    while (pend != '0) begin
      for (int k = 0; k < N; k++) begin
        c = (rr_model + k) % N;
        if (pend[c]) begin
          order.push_back(c);
          pend[c] = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
          rr_model = (c + 1) % N;
`endif
          break;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      addr_cache_to_sdram[i] = c_addr[i];
      transSize[i]           = c_size[i];
    end
    readReq = mask;
    foreach (order[g]) begin
      int w;
      w = order[g];
      wait_req(waited);
      if (!sdram_req) begin
        check("req_timeout", 64'd0, 64'd1);
        abort = 1'b1;
        return;
      end
      if (g > 0) check("b2b_grant_latency", 64'(waited), 64'd1);
      check("sdram_addr", 64'(sdram_addr), 64'(c_addr[w]));
      check("sdram_size", 64'(sdram_size), 64'(c_size[w]));
      stall = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        sdram_rvalid = 1'($urandom_range(0, 1));
        sdram_rdata  = $urandom;
        step();
        check("req_held", 64'(sdram_req), 64'd1);
        check("addr_held", 64'(sdram_addr), 64'(c_addr[w]));
        check("size_held", 64'(sdram_size), 64'(c_size[w]));
      end
      sdram_ack    = 1'b1;
      sdram_rvalid = 1'($urandom_range(0, 1));
      sdram_rdata  = $urandom;
      step();
      sdram_ack    = 1'b0;
      sdram_rvalid = 1'b0;
      check("req_drop_after_ack", 64'(sdram_req), 64'd0);
      for (int b = 0; b <= int'(c_size[w]); b++) begin
        if (gap_mode == 0)      gap = int'($urandom_range(0, 3));
        else if (gap_mode == 1) gap = 0;
        else                    gap = gap_pat[b];
        repeat (gap) step();
        d = (data_base != 0) ? DATA_W'(data_base + b) : DATA_W'($urandom);
        sdram_rvalid = 1'b1;
        sdram_rdata  = d;
        exp_q.push_back({32'(cyc + 1), 8'(w), 1'(b == int'(c_size[w])), d});
        step();
        sdram_rvalid = 1'b0;
      end
    end
    // stray beats while idle must produce nothing
    repeat (3) begin
      sdram_rvalid = 1'($urandom_range(0, 1));
      sdram_rdata  = $urandom;
      step();
    end
    sdram_rvalid = 1'b0;
    repeat (2) step();
    check("round_drained", 64'(exp_q.size()), 64'd0);
    check("clients_released", 64'(readReq), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [EXP_W-1:0] e;
    int e_cyc;
    int e_cli;
    logic e_last;
    logic [DATA_W-1:0] e_data;
    forever begin
      @(posedge clk);
      #1;
      if (readValid_out != '0 || doneRead != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 64'({readValid_out, doneRead}), 64'd0);
        end else begin
          e      = exp_q.pop_front();
          e_cyc  = int'(e[EXP_W-1 -: 32]);
          e_cli  = int'(e[DATA_W+1 +: 8]);
          e_last = e[DATA_W];
          e_data = e[DATA_W-1:0];
          check("beat_latency", 64'(cyc), 64'(e_cyc));
          check("readValid_out", 64'(readValid_out), 64'(1) << e_cli);
          check("doneRead", 64'(doneRead), e_last ? (64'(1) << e_cli) : 64'd0);
          for (int i = 0; i < N; i++) check("readData", 64'(readData[i]), 64'(e_data));
        end
      end
    end
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete in time (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int waited;
    rst                 = 1'b0;
    readReq             = '0;
    addr_cache_to_sdram = '0;
    transSize           = '0;
    sdram_ack           = 1'b0;
    sdram_rvalid        = 1'b0;
    sdram_rdata         = '0;
    gap_mode            = 0;
    stall_fixed         = -1;
    data_base           = 0;
    rr_model            = 0;
    abort               = 1'b0;
    for (int i = 0; i < N; i++) begin
      c_addr[i] = '0;
      c_size[i] = '0;
    end
    repeat (3) step();
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    check("reset_sdram_req", 64'(sdram_req), 64'd0);
    check("reset_strobes", 64'({readValid_out, doneRead}), 64'd0);
    check("reset_sdram_addr", 64'(sdram_addr), 64'd0);
    check("reset_sdram_size", 64'(sdram_size), 64'd0);
    check("reset_readData", 64'(readData[0]), 64'd0);
    rst = 1'b1;
    repeat (2) step();

    // single request, known data
    c_addr[1] = 25'h00100; c_size[1] = 4'd3;
    stall_fixed = 3; data_base = 32'hA0;
    run_round(3'b010);
    stall_fixed = -1; data_base = 0;

    // contention, twice, single-beat bursts
    for (int i = 0; i < N; i++) begin
      c_addr[i] = ADDR_W'($urandom); c_size[i] = '0;
    end
    run_round(3'b111);
    run_round(3'b111);

    // maximum bursts, continuous beats, back to back
    gap_mode = 1;
    c_size[0] = 4'd15; c_size[2] = 4'd15;
    run_round(3'b101);

    // gapped beats t, t+3, t+7
    gap_mode = 2; gap_pat = '{0, 2, 3};
    c_size[0] = 4'd2;
    run_round(3'b001);
    gap_mode = 0;

    // ack withheld 50 cycles
    stall_fixed = 50; c_size[2] = 4'd1;
    run_round(3'b100);
    stall_fixed = -1;

    // random rounds
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        c_addr[i] = ADDR_W'($urandom);
        c_size[i] = SZ_W'($urandom_range(0, MAX_TRANS - 1));
      end
      run_round(N'($urandom_range(1, (1 << N) - 1)));
    end

    // reset mid-burst: complete a client 1 burst first, then abort a second one
    if (!abort) begin
      c_addr[1] = 25'h1ABCD; c_size[1] = 4'd1;
      run_round(3'b010);
    end
    if (!abort) begin
      addr_cache_to_sdram[1] = 25'h1ABCD;
      transSize[1]           = 4'd7;
      readReq                = 3'b010;
      wait_req(waited);
      check("abort_req_seen", 64'(sdram_req), 64'd1);
      sdram_ack = 1'b1;
      step();
      sdram_ack = 1'b0;
      for (int b = 0; b < 2; b++) begin
        sdram_rvalid = 1'b1;
        sdram_rdata  = 32'h55 + b;
        exp_q.push_back({32'(cyc + 1), 8'd1, 1'b0, DATA_W'(32'h55 + b)});
        step();
        sdram_rvalid = 1'b0;
      end
      repeat (2) step();
      check("abort_beats_drained", 64'(exp_q.size()), 64'd0);
      rst = 1'b0;
      #1;
      check("midrst_state", 64'(dbg_state), 64'(IDLE));
      check("midrst_sdram_req", 64'(sdram_req), 64'd0);
      check("midrst_sdram_addr", 64'(sdram_addr), 64'd0);
      check("midrst_sdram_size", 64'(sdram_size), 64'd0);
      check("midrst_strobes", 64'({readValid_out, doneRead}), 64'd0);
      for (int i = 0; i < N; i++) check("midrst_readData", 64'(readData[i]), 64'd0);
      readReq  = '0;
      rr_model = 0;
      repeat (3) begin
        sdram_rvalid = 1'b1;
        sdram_rdata  = $urandom;
        step();
      end
      rst = 1'b1;
      repeat (3) begin
        sdram_rvalid = 1'b1;
        sdram_rdata  = $urandom;
        step();
        check("post_rst_idle", 64'(dbg_state), 64'(IDLE));
      end
      sdram_rvalid = 1'b0;
      c_size[0] = 4'd1; c_size[2] = 4'd1;
      c_addr[0] = 25'h00042; c_addr[2] = 25'h01234;
      run_round(3'b101);
    end

    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
